// File: rtl/ram_trace_packetizer.sv
// Turns completed RAM-bus accesses into 6-byte framed trace packets for the FX2 EP6 slave FIFO.
// Events queue in a small FIFO; events arriving while it is full are dropped, counted and flagged.
module ram_trace_packetizer #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int DROP_CTR_W      = 16
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  ram_read_sync,
    input  logic                  ram_write_sync,
    input  logic [22:0]           ram_a_sync,
    input  logic [15:0]           ram_d_sync,
    input  logic                  usb_flagb,
    output logic [7:0]            usb_d,
    output logic                  usb_slwr,
    output logic                  overflow,
    output logic [DROP_CTR_W-1:0] drop_count,
    output logic [1:0]            dbg_state_o
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int AW    = FIFO_DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic                  prev_rd_q, prev_wr_q;
    logic [22:0]           prev_a_q;
    logic [15:0]           prev_d_q;
    logic [39:0]           mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, rd_ptr_q;
    logic [2:0]            idx_q, idx_d;
    logic [39:0]           pkt_q, pkt_d;
    logic [7:0]            usb_d_q, usb_d_d;
    logic                  slwr_q, slwr_d;
    logic                  pend_q, pend_d;
    logic                  ovf_q;
    logic [DROP_CTR_W-1:0] dc_q;

    logic        wr_evt, rd_evt, evt;
    logic [39:0] evt_entry, fifo_rd;
    logic        fifo_empty, fifo_full, push, drop, pop;
    logic [47:0] new_pkt;

    // An access completes on the falling strobe; a simultaneous write end wins over a read end.
    assign wr_evt    = prev_wr_q & ~ram_write_sync;
    assign rd_evt    = prev_rd_q & ~ram_read_sync;
    assign evt       = wr_evt | rd_evt;
    assign evt_entry = {wr_evt, prev_a_q, prev_d_q};

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = evt & ~fifo_full;
    assign drop       = evt & fifo_full;
    assign fifo_rd    = mem_q[rd_ptr_q[AW-1:0]];

    assign new_pkt = {1'b1, fifo_rd[39], pend_q, fifo_rd[38:34],
                      1'b0, fifo_rd[33:27],
                      1'b0, fifo_rd[26:20],
                      1'b0, fifo_rd[19:16], fifo_rd[15:13],
                      1'b0, fifo_rd[12:6],
                      1'b0, fifo_rd[5:0], 1'b0};

    // A drop coinciding with a pop keeps the flag for the following packet.
    assign pend_d = (pend_q & ~pop) | drop;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pkt_d   = pkt_q;
        usb_d_d = usb_d_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    usb_d_d = new_pkt[47:40];
                    pkt_d   = new_pkt[39:0];
                    idx_d   = 3'd0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (usb_flagb) state_d = S_STROBE;
            end
            S_STROBE: state_d = S_HOLD;
            S_HOLD: begin
                if (idx_q == 3'd5) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    usb_d_d = pkt_q[39:32];
                    pkt_d   = {pkt_q[31:0], 8'h00};
                    state_d = S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
        slwr_d = (state_d != S_STROBE);
    end

    always_ff @(posedge mclk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= evt_entry;
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            prev_rd_q <= 1'b0;
            prev_wr_q <= 1'b0;
            prev_a_q  <= '0;
            prev_d_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            idx_q     <= '0;
            pkt_q     <= '0;
            usb_d_q   <= '0;
            slwr_q    <= 1'b1;
            pend_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dc_q      <= '0;
        end else begin
            state_q   <= state_d;
            prev_rd_q <= ram_read_sync;
            prev_wr_q <= ram_write_sync;
            prev_a_q  <= ram_a_sync;
            prev_d_q  <= ram_d_sync;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            idx_q     <= idx_d;
            pkt_q     <= pkt_d;
            usb_d_q   <= usb_d_d;
            slwr_q    <= slwr_d;
            pend_q    <= pend_d;
            ovf_q     <= drop;
            if (drop && (dc_q != '1)) dc_q <= dc_q + 1'b1;
        end
    end

    assign usb_d       = usb_d_q;
    assign usb_slwr    = slwr_q;
    assign overflow    = ovf_q;
    assign drop_count  = dc_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_ram_trace_packetizer.sv
// Bench for ram_trace_packetizer: table of single-event packets, hand-written stall/overflow/reset
// sequences, and a randomized run checked against a schedule-based reference model.
module tb_ram_trace_packetizer;
    logic        mclk = 1'b0;
    logic        reset, ram_read_sync, ram_write_sync, usb_flagb;
    logic [22:0] ram_a_sync;
    logic [15:0] ram_d_sync;
    logic [7:0]  usb_d;
    logic        usb_slwr, overflow;
    logic [15:0] drop_count;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    ram_trace_packetizer #(.FIFO_DEPTH_LOG2(4), .DROP_CTR_W(16)) dut (
        .mclk(mclk), .reset(reset),
        .ram_read_sync(ram_read_sync), .ram_write_sync(ram_write_sync),
        .ram_a_sync(ram_a_sync), .ram_d_sync(ram_d_sync),
        .usb_flagb(usb_flagb), .usb_d(usb_d), .usb_slwr(usb_slwr),
        .overflow(overflow), .drop_count(drop_count), .dbg_state_o(dbg_state)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet bytes built from the field rules with plain arithmetic.
    function automatic logic [47:0] pack(input logic t, input logic o,
                                         input logic [22:0] a, input logic [15:0] d);
        int ai, di, b0, b1, b2, b3, b4, b5;
        ai = int'(a);
        di = int'(d);
        b0 = 128 + (t ? 64 : 0) + (o ? 32 : 0) + (ai / 262144);
        b1 = (ai / 2048) % 128;
        b2 = (ai / 16) % 128;
        b3 = (ai % 16) * 8 + (di / 8192);
        b4 = (di / 64) % 128;
        b5 = (di % 64) * 2;
        return {8'(b0), 8'(b1), 8'(b2), 8'(b3), 8'(b4), 8'(b5)};
    endfunction

    task automatic do_reset();
        @(negedge mclk);
        reset = 1'b1; ram_read_sync = 1'b0; ram_write_sync = 1'b0;
        ram_a_sync = '0; ram_d_sync = '0; usb_flagb = 1'b1;
        @(negedge mclk);
        @(negedge mclk);
        reset = 1'b0;
    endtask

    logic [7:0] got_q[$];
    int first_k, ovf_seen, quiet_strobes;

    task automatic collect(input int nbytes, input int budget);
        got_q.delete();
        first_k = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge mclk);
            if (overflow) ovf_seen++;
            if (!usb_slwr) begin
                if (first_k < 0) first_k = k;
                got_q.push_back(usb_d);
            end
            if (got_q.size() == nbytes) break;
        end
    endtask

    task automatic quiet(input int n);
        quiet_strobes = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge mclk);
            if (overflow) ovf_seen++;
            if (!usb_slwr) quiet_strobes++;
        end
    endtask

    function automatic logic [47:0] got_pkt(input int base);
        logic [47:0] g;
        g = '0;
        for (int i = 0; i < 6; i++)
            if (base + i < got_q.size()) g[47-8*i -: 8] = got_q[base + i];
        return g;
    endfunction

    typedef struct {
        logic        wr;
        logic        rd;
        logic [22:0] a;
        logic [15:0] d;
        int          hold;
        logic [47:0] exp_pkt;
    } vec_t;
    vec_t vecs[5];

    // Random-run stimulus and expected per-cycle outputs.
    localparam int N = 2500;
    logic        w_a[N], r_a[N], f_a[N];
    logic [22:0] a_a[N];
    logic [15:0] d_a[N];
    logic        exp_slwr[N], exp_dv[N], exp_ovf[N];
    logic [7:0]  exp_d[N];
    logic [15:0] exp_dc[N];
    logic [39:0] ev_q[$];

    task automatic build_model();
        int free_at, dc, start, s;
        logic pend, pw, pr, we, re, ev, full, pop, drop;
        logic [39:0] e;
        logic [47:0] bytes;
        free_at = 0; dc = 0; pend = 1'b0;
        ev_q.delete();
        for (int c = 0; c < N; c++) begin
            exp_slwr[c] = 1'b1; exp_dv[c] = 1'b0; exp_ovf[c] = 1'b0;
            exp_d[c] = '0; exp_dc[c] = '0;
        end
        for (int c = 0; c < N; c++) begin
            pw   = (c > 0) ? w_a[c-1] : 1'b0;
            pr   = (c > 0) ? r_a[c-1] : 1'b0;
            we   = pw && !w_a[c];
            re   = pr && !r_a[c];
            ev   = we || re;
            full = (ev_q.size() == 16);
            pop  = (c >= free_at) && (ev_q.size() > 0);
            drop = ev && full;
            if (pop) begin
                e = ev_q.pop_front();
                bytes = pack(e[39], pend, e[38:16], e[15:0]);
                start = c + 1;
                for (int k = 0; k < 6; k++) begin
                    s = start;
                    while (s < N - 3 && !f_a[s]) s++;
                    for (int t = start; t <= s + 2; t++)
                        if (t < N) begin
                            exp_dv[t] = 1'b1;
                            exp_d[t]  = bytes[47-8*k -: 8];
                        end
                    if (s + 1 < N) exp_slwr[s+1] = 1'b0;
                    start = s + 3;
                end
                free_at = start;
            end
            pend = (pend && !pop) || drop;
            if (ev && !full) ev_q.push_back({we, a_a[c-1], d_a[c-1]});
            if (drop) begin
                if (dc < 65535) dc++;
                if (c + 1 < N) exp_ovf[c+1] = 1'b1;
            end
            if (c + 1 < N) exp_dc[c+1] = 16'(dc);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, bad_slwr, bad_d, stall_strobes, seen;
        vecs[0] = '{1'b1, 1'b0, 23'h123456, 16'hBEEF, 3, 48'hC446_4535_7B5E};
        vecs[1] = '{1'b0, 1'b1, 23'h000000, 16'h0000, 1, 48'h8000_0000_0000};
        vecs[2] = '{1'b1, 1'b1, 23'h7FFFFF, 16'hFFFF, 2, 48'hDF7F_7F7F_7F7E};
        vecs[3] = '{1'b0, 1'b1, 23'h400001, 16'h8001, 1, 48'h9000_000C_0002};
        vecs[4] = '{1'b1, 1'b0, 23'h2AAAAA, 16'h5555, 4, 48'hCA55_2A52_552A};

        reset = 1'b1; ram_read_sync = 1'b0; ram_write_sync = 1'b0;
        ram_a_sync = '0; ram_d_sync = '0; usb_flagb = 1'b1;

        // Reset state
        do_reset();
        chk("rst_slwr", 48'(usb_slwr), 48'(1));
        chk("rst_usb_d", 48'(usb_d), 48'(0));
        chk("rst_overflow", 48'(overflow), 48'(0));
        chk("rst_drop_count", 48'(drop_count), 48'(0));
        chk("rst_state", 48'(dbg_state), 48'(0));

        // Single-event packets
        for (int v = 0; v < 5; v++) begin
            do_reset();
            ovf_seen = 0;
            ram_write_sync = vecs[v].wr; ram_read_sync = vecs[v].rd;
            ram_a_sync = vecs[v].a; ram_d_sync = vecs[v].d;
            repeat (vecs[v].hold) @(negedge mclk);
            ram_write_sync = 1'b0; ram_read_sync = 1'b0;
            ram_a_sync = 23'($urandom()); ram_d_sync = 16'($urandom());
            collect(6, 60);
            chk($sformatf("vec%0d_latency", v), 48'(first_k), 48'(3));
            chk($sformatf("vec%0d_nbytes", v), 48'(got_q.size()), 48'(6));
            chk($sformatf("vec%0d_packet", v), got_pkt(0), vecs[v].exp_pkt);
            quiet(30);
            chk($sformatf("vec%0d_extra_strobes", v), 48'(quiet_strobes), 48'(0));
            chk($sformatf("vec%0d_overflow", v), 48'(ovf_seen), 48'(0));
        end

        // Backpressure stall holding b0
        do_reset();
        usb_flagb = 1'b0;
        ram_read_sync = 1'b1; ram_a_sync = '0; ram_d_sync = '0;
        @(negedge mclk);
        ram_read_sync = 1'b0;
        bad_slwr = 0; bad_d = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge mclk);
            if (!usb_slwr) bad_slwr++;
            if (k >= 2 && usb_d !== 8'h80) bad_d++;
        end
        chk("stall_slwr_low_count", 48'(bad_slwr), 48'(0));
        chk("stall_usb_d_not_b0", 48'(bad_d), 48'(0));
        usb_flagb = 1'b1;
        collect(6, 60);
        chk("stall_packet", got_pkt(0), 48'h8000_0000_0000);

        // 20 back-to-back write events while stalled: one popped, 16 queued, 3 dropped
        do_reset();
        usb_flagb = 1'b0;
        pulses = 0; stall_strobes = 0;
        for (int i = 0; i < 20; i++) begin
            ram_write_sync = 1'b1; ram_a_sync = 23'(i + 1); ram_d_sync = 16'(i * 3 + 1);
            @(negedge mclk);
            if (overflow) pulses++;
            if (!usb_slwr) stall_strobes++;
            ram_write_sync = 1'b0;
            @(negedge mclk);
            if (overflow) pulses++;
            if (!usb_slwr) stall_strobes++;
        end
        repeat (4) begin
            @(negedge mclk);
            if (overflow) pulses++;
            if (!usb_slwr) stall_strobes++;
        end
        chk("ovf_pulses", 48'(pulses), 48'(3));
        chk("ovf_drop_count", 48'(drop_count), 48'(3));
        chk("ovf_stall_strobes", 48'(stall_strobes), 48'(0));
        usb_flagb = 1'b1;
        collect(102, 2500);
        chk("ovf_nbytes", 48'(got_q.size()), 48'(102));
        for (int j = 0; j < 17; j++)
            chk($sformatf("ovf_pkt%0d", j), got_pkt(6 * j),
                pack(1'b1, j == 1, 23'(j + 1), 16'(j * 3 + 1)));

        // Reset in the middle of a packet with another event still queued
        usb_flagb = 1'b1;
        ram_write_sync = 1'b1; ram_a_sync = 23'h123456; ram_d_sync = 16'hBEEF;
        @(negedge mclk);
        ram_write_sync = 1'b0; ram_read_sync = 1'b1; ram_a_sync = 23'h5; ram_d_sync = 16'h7;
        @(negedge mclk);
        ram_read_sync = 1'b0;
        seen = 0;
        for (int k = 0; k < 100 && seen < 3; k++) begin
            @(negedge mclk);
            if (!usb_slwr) seen++;
        end
        chk("mid_strobes_before_reset", 48'(seen), 48'(3));
        reset = 1'b1;
        @(negedge mclk);
        reset = 1'b0;
        chk("mid_rst_slwr", 48'(usb_slwr), 48'(1));
        chk("mid_rst_drop_count", 48'(drop_count), 48'(0));
        chk("mid_rst_usb_d", 48'(usb_d), 48'(0));
        quiet(40);
        chk("mid_rst_fifo_empty", 48'(quiet_strobes), 48'(0));
        ram_write_sync = 1'b1; ram_a_sync = 23'h000010; ram_d_sync = 16'h0001;
        @(negedge mclk);
        ram_write_sync = 1'b0;
        collect(6, 60);
        chk("mid_post_marker", 48'(got_q.size() > 0 ? got_q[0][7] : 1'b0), 48'(1));
        chk("mid_post_packet", got_pkt(0), pack(1'b1, 1'b0, 23'h000010, 16'h0001));

        // Randomized run against the reference model
        for (int c = 0; c < N; c++) begin
            int p;
            p = ((c / 250) % 2 == 1) ? 35 : 6;
            a_a[c] = 23'($urandom());
            d_a[c] = 16'($urandom());
            if (c < 2000) begin
                w_a[c] = ($urandom_range(0, 99) < p);
                r_a[c] = ($urandom_range(0, 99) < p);
                f_a[c] = (c >= 600 && c < 850) ? 1'b0 : ($urandom_range(0, 99) < 80);
            end else begin
                w_a[c] = 1'b0; r_a[c] = 1'b0; f_a[c] = 1'b1;
            end
        end
        build_model();
        do_reset();
        for (int c = 0; c < N; c++) begin
            chk($sformatf("rnd_slwr@%0d", c), 48'(usb_slwr), 48'(exp_slwr[c]));
            if (exp_dv[c]) chk($sformatf("rnd_usb_d@%0d", c), 48'(usb_d), 48'(exp_d[c]));
            chk($sformatf("rnd_overflow@%0d", c), 48'(overflow), 48'(exp_ovf[c]));
            chk($sformatf("rnd_drop_count@%0d", c), 48'(drop_count), 48'(exp_dc[c]));
            ram_write_sync = w_a[c]; ram_read_sync = r_a[c];
            ram_a_sync = a_a[c]; ram_d_sync = d_a[c]; usb_flagb = f_a[c];
            @(negedge mclk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
